// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch controller.
//   sw_state_e : control FSM states
//   sw_time_t  : packed hh:mm:ss.cc time value
//   *_W / *_MAX: field widths and wrap limits of the time counter
package stopwatch_pkg;

  localparam int HOUR_W = 6;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int CS_W   = 7;

  localparam int M_SEC_MAX = 99;
  localparam int SEC_MAX   = 59;
  localparam int MIN_MAX   = 59;
  localparam int HOUR_MAX  = 23;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSE     = 3'd2,
    LAP_RUN   = 3'd3,
    LAP_PAUSE = 3'd4
  } sw_state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] h;
    logic [MIN_W-1:0]  m;
    logic [SEC_W-1:0]  s;
    logic [CS_W-1:0]   cs;
  } sw_time_t;

  // Prescaler advances only while the stopwatch is running.
  function automatic logic is_counting(sw_state_e st);
    return (st == RUN) || (st == LAP_RUN);
  endfunction

endpackage

// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: cascaded hh:mm:ss.cc live counter.
//   clock, reset : rising-edge clock, async active-high reset
//   clr          : synchronous clear to 00:00:00.00 (wins over tick)
//   tick         : advance by one centisecond at the next edge
//   h/m/s/cs     : current live time
module stopwatch_time_counter
  import stopwatch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              tick,
  output logic [HOUR_W-1:0] h,
  output logic [MIN_W-1:0]  m,
  output logic [SEC_W-1:0]  s,
  output logic [CS_W-1:0]   cs
);

  logic [HOUR_W-1:0] h_q;
  logic [MIN_W-1:0]  m_q;
  logic [SEC_W-1:0]  s_q;
  logic [CS_W-1:0]   cs_q;

  // Each field carries into the next only when it wraps; 23:59:59.99
  // rolls over to all zeros with no further effect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q  <= '0;
      m_q  <= '0;
      s_q  <= '0;
      cs_q <= '0;
    end else if (clr) begin
      h_q  <= '0;
      m_q  <= '0;
      s_q  <= '0;
      cs_q <= '0;
    end else if (tick) begin
      if (cs_q == CS_W'(M_SEC_MAX)) begin
        cs_q <= '0;
        if (s_q == SEC_W'(SEC_MAX)) begin
          s_q <= '0;
          if (m_q == MIN_W'(MIN_MAX)) begin
            m_q <= '0;
            h_q <= (h_q == HOUR_W'(HOUR_MAX)) ? '0 : h_q + 1'b1;
          end else begin
            m_q <= m_q + 1'b1;
          end
        end else begin
          s_q <= s_q + 1'b1;
        end
      end else begin
        cs_q <= cs_q + 1'b1;
      end
    end
  end

  assign h  = h_q;
  assign m  = m_q;
  assign s  = s_q;
  assign cs = cs_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch with run/pause, lap freeze and clear.
//   TICK_DIV    : clock cycles per centisecond (2 .. 2^20)
//   clock/reset : rising-edge clock, async active-high reset
//   start_pause, lap, clear : debounced levels, act on rising edge
//   hour/minute/second/m_sec: lap registers while lap_active, else live time
//   running     : high in RUN / LAP_RUN
//   lap_active  : high in LAP_RUN / LAP_PAUSE
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_pause,
  input  logic              lap,
  input  logic              clear,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic [CS_W-1:0]   m_sec,
  output logic              running,
  output logic              lap_active
);

  localparam int             PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PS_LAST = PW'(TICK_DIV - 1);

  // ---------------- edge detect ----------------
  // armed stays low for the first clock after reset so that a button
  // already held at release only loads btn_prev and never fires.
  logic [2:0] btn_now, btn_prev, btn_pulse;
  logic       armed;
  logic       sp_p, lap_p, clr_p;

  assign btn_now = {clear, start_pause, lap};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_prev <= '0;
      armed    <= 1'b0;
    end else begin
      btn_prev <= btn_now;
      armed    <= 1'b1;
    end
  end

  assign btn_pulse = armed ? (btn_now & ~btn_prev) : 3'b000;
  assign clr_p     = btn_pulse[2];
  assign sp_p      = btn_pulse[1];
  assign lap_p     = btn_pulse[0];

  // ---------------- FSM ----------------
  sw_state_e state, state_n;
  logic      lap_cap, do_clr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Priority clear > start_pause > lap is applied among the actions that
  // are legal in the current state; an ignored button does not mask a
  // lower-priority one.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (sp_p) state_n = RUN;
      RUN:       if (sp_p) state_n = PAUSE;
                 else if (lap_p) state_n = LAP_RUN;
      PAUSE:     if (clr_p) state_n = IDLE;
                 else if (sp_p) state_n = RUN;
      LAP_RUN:   if (sp_p) state_n = LAP_PAUSE;
                 else if (lap_p) state_n = RUN;
      LAP_PAUSE: if (clr_p) state_n = IDLE;
                 else if (sp_p) state_n = LAP_RUN;
                 else if (lap_p) state_n = PAUSE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    running    = is_counting(state);
    lap_active = (state == LAP_RUN) || (state == LAP_PAUSE);
    lap_cap    = (state == RUN) && (state_n == LAP_RUN);
    do_clr     = (state != IDLE) && (state_n == IDLE);
  end

  // ---------------- prescaler ----------------
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = running && (presc == PS_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         presc <= '0;
    else if (do_clr || state == IDLE)  presc <= '0;
    else if (running)                  presc <= tick ? '0 : presc + 1'b1;
  end

  // ---------------- live time ----------------
  sw_time_t live, lap_q, disp;

  stopwatch_time_counter u_time (
    .clock (clock),
    .reset (reset),
    .clr   (do_clr),
    .tick  (tick),
    .h     (live.h),
    .m     (live.m),
    .s     (live.s),
    .cs    (live.cs)
  );

  // ---------------- lap registers ----------------
  // live is sampled before the edge applies any coincident tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        lap_q <= '0;
    else if (do_clr)  lap_q <= '0;
    else if (lap_cap) lap_q <= live;
  end

  // ---------------- display mux ----------------
  assign disp   = lap_active ? lap_q : live;
  assign hour   = disp.h;
  assign minute = disp.m;
  assign second = disp.s;
  assign m_sec  = disp.cs;

endmodule
